pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Five-stage pipeline hazard / memory-wait controller.
//                Produces the pipeline-register enables and bubble controls
//                from the current control state and the hazard inputs.
//                Handles memory freezes with a bounded wait (TIMEOUT) that
//                falls into a sticky HALT state, taken branches (flush
//                IF/ID and ID/EX), and single-cycle load-use stalls.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk                   rising-edge clock for all state
//    Rst                   synchronous active-high reset
//    IdRs, IdRt [4:0]      source registers of the instruction in ID
//    IdUsesRt              ID instruction reads Rt
//    ExWreg, ExReg2reg     EX instruction writes a register / is a load
//    ExRd [4:0]            EX destination register
//    ExBtaken              branch resolved taken in EX
//    MemReq, MemReady      MEM data access pending / data memory done
//    EnPC..EnMEMWB         pipeline register enables
//    ClrIFID, ClrIDEX      synchronous bubble insert into IF/ID, ID/EX
//    BubMEMWB              MEM/WB captures Wreg=0 on this edge
//    Halted, MemErr        halt state / sticky memory-timeout flag
//    StallCnt [15:0]       saturating count of stall cycles
// ============================================================================
module pipe_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRt,
  input  logic        ExWreg,
  input  logic        ExReg2reg,
  input  logic [4:0]  ExRd,
  input  logic        ExBtaken,
  input  logic        MemReq,
  input  logic        MemReady,
  output logic        EnPC,
  output logic        EnIFID,
  output logic        EnIDEX,
  output logic        EnEXMEM,
  output logic        EnMEMWB,
  output logic        ClrIFID,
  output logic        ClrIDEX,
  output logic        BubMEMWB,
  output logic        Halted,
  output logic        MemErr,
  output logic [15:0] StallCnt
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // Wait-counter value on which the next freeze cycle gives up.
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [7:0]  r_waitCnt;
  logic [7:0]  w_nextWaitCnt;
  logic        r_memErr;
  logic        r_luDone;
  logic [15:0] r_stallCnt;

  logic        w_halt;
  logic        w_mf;
  logic        w_loadUse;
  logic        w_luStall;
  logic        w_stallCycle;

  assign w_halt = (r_state == S_HALT);

  // Memory freeze: only meaningful while running or waiting.
  assign w_mf = MemReq & ~MemReady & ~w_halt;

  assign w_loadUse = ExWreg & ExReg2reg & (ExRd != 5'd0) &
                     ((ExRd == IdRs) | (IdUsesRt & (ExRd == IdRt)));

  // A load-use stall never repeats back to back: after one stall cycle the
  // load has moved on and ID/EX holds a bubble, so a still-asserted compare
  // is stale and must not stall again.
  assign w_luStall = w_loadUse & ~r_luDone;

  // ---------------------------------------------------------------------
  // Enables / clears (combinational, priority HALT > MF > branch > LU)
  // ---------------------------------------------------------------------
  always_comb begin
    EnPC     = 1'b1;
    EnIFID   = 1'b1;
    EnIDEX   = 1'b1;
    EnEXMEM  = 1'b1;
    EnMEMWB  = 1'b1;
    ClrIFID  = 1'b0;
    ClrIDEX  = 1'b0;
    BubMEMWB = 1'b0;
    if (Rst) begin
      EnPC     = 1'b0;
      EnIFID   = 1'b0;
      EnIDEX   = 1'b0;
      EnEXMEM  = 1'b0;
      EnMEMWB  = 1'b0;
      ClrIFID  = 1'b1;
      ClrIDEX  = 1'b1;
      BubMEMWB = 1'b1;
    end else if (w_halt) begin
      EnPC     = 1'b0;
      EnIFID   = 1'b0;
      EnIDEX   = 1'b0;
      EnEXMEM  = 1'b0;
      EnMEMWB  = 1'b0;
    end else if (w_mf) begin
      // Freeze everything upstream; MEM/WB keeps flowing with a bubble so
      // the instruction ahead of the stalled access can retire.
      EnPC     = 1'b0;
      EnIFID   = 1'b0;
      EnIDEX   = 1'b0;
      EnEXMEM  = 1'b0;
      BubMEMWB = 1'b1;
    end else if (ExBtaken) begin
      ClrIFID  = 1'b1;
      ClrIDEX  = 1'b1;
    end else if (w_luStall) begin
      EnPC     = 1'b0;
      EnIFID   = 1'b0;
      ClrIDEX  = 1'b1;
    end
  end

  assign Halted   = w_halt;
  assign MemErr   = r_memErr;
  assign StallCnt = r_stallCnt;

  assign w_stallCycle = ~EnPC & ~w_halt;

  // ---------------------------------------------------------------------
  // Next state / wait counter
  // ---------------------------------------------------------------------
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    case (r_state)
      S_RUN, S_WAIT: begin
        if (w_mf) begin
          if (r_waitCnt == c_WAIT_LAST) begin
            w_nextState   = S_HALT;
            w_nextWaitCnt = r_waitCnt;
          end else begin
            w_nextState   = S_WAIT;
            w_nextWaitCnt = r_waitCnt + 8'd1;
          end
        end else begin
          // Release (or no access): pipeline advances this cycle.
          w_nextState   = S_RUN;
          w_nextWaitCnt = 8'd0;
        end
      end
      S_HALT: begin
        w_nextState   = S_HALT;
        w_nextWaitCnt = r_waitCnt;
      end
      default: begin
        w_nextState   = S_RUN;
        w_nextWaitCnt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_RUN;
      r_waitCnt  <= 8'd0;
      r_memErr   <= 1'b0;
      r_luDone   <= 1'b0;
      r_stallCnt <= 16'd0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_mf && (r_waitCnt == c_WAIT_LAST)) begin
        r_memErr <= 1'b1;
      end
      r_luDone <= ~w_halt & ~w_mf & ~ExBtaken & w_luStall;
      if (w_stallCycle && (r_stallCnt != 16'hFFFF)) begin
        r_stallCnt <= r_stallCnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
